// File: rtl/tff_counter_pkg.sv
// Shared mode encoding for the T flip-flop counter bank.
package tff_counter_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_COUNT  = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

endpackage : tff_counter_pkg

// File: rtl/tff_cell.sv
// Single T flip-flop cell with synchronous active-high reset to a per-bit value.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic t,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignment so every cell samples pre-edge values.
  always_ff @(posedge clk) begin
    q <= rst ? rst_val : (q ^ t);
  end

endmodule : tff_cell

// File: rtl/tff_counter_bank.sv
// WIDTH-bit hold/toggle/count/load register built from T cells, with terminal-count and sticky overflow flags.
module tff_counter_bank
  import tff_counter_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             down,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] tvec;
  logic             at_term;
  logic             ovf_set;

  assign at_term = down ? (q == '0) : (q == '1);
  assign tc      = (mode == MODE_COUNT) && at_term;

  // Ripple toggle chain: bit i flips once every lower bit is at its carry/borrow value.
  always_comb begin
    chain    = '0;
    chain[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      chain[i] = chain[i-1] & (down ? ~q[i-1] : q[i-1]);
    end
  end

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    tvec    = '0;
    ovf_set = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_TOGGLE: tvec = t;
        MODE_LOAD:   tvec = q ^ load_val;
        MODE_COUNT: begin
          tvec = chain;
          if (at_term) begin
            ovf_set = 1'b1;
            if (SATURATE) tvec = '0;
          end
        end
        default:     tvec = '0;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i]),
      .t       (tvec[i]),
      .q       (q[i])
    );
  end

  // A set in the same cycle as a clear wins, so a fresh overflow is never lost.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule : tff_counter_bank
